// File: rtl/div_unit_if.sv
// Operand/request and result bundle between the core datapath and the
// iterative divider; the core drives the request side, the divider the results.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       aluControl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             kill;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, aluControl, A, B, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, aluControl, A, B, kill,
    output busy, done, result
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: special cases and |A|<|B| finish without iterating.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic       clk,
  input  logic       reset_n,
  div_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] OP_DIV  = 5'h0e;
  localparam logic [4:0] OP_DIVU = 5'h0f;
  localparam logic [4:0] OP_REM  = 5'h10;
  localparam logic [4:0] OP_REMU = 5'h11;

  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Two's complement negation mod 2^WIDTH when n is set.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_is_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_special;
  logic [WIDTH-1:0] r_spec_val;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;

  logic             w_valid_op;
  logic             w_signed;
  logic             w_is_rem;
  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_b_zero;
  logic             w_ovf;
  logic             w_special;
  logic [WIDTH-1:0] w_spec_val;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_fin;

  // Opcode decode: which codes are requests, signedness, quotient vs remainder.
  always_comb begin
    w_valid_op = 1'b0;
    w_signed   = 1'b0;
    w_is_rem   = 1'b0;
    case (bus.aluControl)
      OP_DIV: begin
        w_valid_op = 1'b1;
        w_signed   = 1'b1;
      end
      OP_DIVU: begin
        w_valid_op = 1'b1;
      end
      OP_REM: begin
        w_valid_op = 1'b1;
        w_signed   = 1'b1;
        w_is_rem   = 1'b1;
      end
      OP_REMU: begin
        w_valid_op = 1'b1;
        w_is_rem   = 1'b1;
      end
      default: begin
        w_valid_op = 1'b0;
        w_signed   = 1'b0;
        w_is_rem   = 1'b0;
      end
    endcase
  end

  // A kill in the same cycle as a request wins, so nothing is latched.
  assign w_accept  = (r_state == S_IDLE) && bus.start && w_valid_op && !bus.kill;
  assign w_a_neg   = w_signed && bus.A[WIDTH-1];
  assign w_b_neg   = w_signed && bus.B[WIDTH-1];
  assign w_a_mag   = neg_if(bus.A, w_a_neg);
  assign w_b_mag   = neg_if(bus.B, w_b_neg);
  assign w_b_zero  = (bus.B == ZERO);
  assign w_ovf     = w_signed && (bus.A == MOST_NEG) && (bus.B == ALL_ONES);
  assign w_special = w_b_zero || w_ovf;

  // RISC-V values for divide-by-zero and signed overflow.
  always_comb begin
    if (w_b_zero) begin
      w_spec_val = w_is_rem ? bus.A : ALL_ONES;
    end else if (w_ovf) begin
      w_spec_val = w_is_rem ? ZERO : bus.A;
    end else begin
      w_spec_val = ZERO;
    end
  end

`ifdef DIV_EARLY_OUT_EN
  logic             w_early;
  logic [WIDTH-1:0] w_early_val;

  assign w_early     = w_special || (w_a_mag < w_b_mag);
  assign w_early_val = w_special ? w_spec_val : (w_is_rem ? bus.A : ZERO);
`endif

  // One restoring step plus the sign fix-up applied to the final step's output.
  always_comb begin
    w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_div};
    if (!w_trial[WIDTH]) begin
      w_rem_nxt = w_trial[WIDTH-1:0];
      w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
    end else begin
      w_rem_nxt = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
      w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
    end
    if (r_special) begin
      w_fin = r_spec_val;
    end else if (r_is_rem) begin
      w_fin = neg_if(w_rem_nxt, r_neg_r);
    end else begin
      w_fin = neg_if(w_quo_nxt, r_neg_q);
    end
  end

  // Control FSM and datapath registers; result only changes on entry to DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= CNT_ZERO;
      r_rem      <= ZERO;
      r_quo      <= ZERO;
      r_div      <= ZERO;
      r_is_rem   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_special  <= 1'b0;
      r_spec_val <= ZERO;
      r_result   <= ZERO;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rem      <= ZERO;
            r_quo      <= w_a_mag;
            r_div      <= w_b_mag;
            r_is_rem   <= w_is_rem;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_special  <= w_special;
            r_spec_val <= w_spec_val;
            r_busy     <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
            if (w_early) begin
              r_state  <= S_DONE;
              r_cnt    <= CNT_ZERO;
              r_result <= w_early_val;
              r_done   <= 1'b1;
            end else begin
              r_state  <= S_CALC;
              r_cnt    <= CNT_FULL;
            end
`else
            r_state <= S_CALC;
            r_cnt   <= CNT_FULL;
`endif
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_CALC: begin
          if (bus.kill) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
            r_busy  <= 1'b0;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
              r_state  <= S_DONE;
              r_result <= w_fin;
              r_done   <= 1'b1;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= CNT_ZERO;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule
